// File: rtl/ovl_fifo_index_mc_pkg.sv
// Shared constants for the multi-channel FIFO index checker: fire bit layout
// and the occupancy counter width.
package ovl_fifo_index_mc_pkg;

    localparam int FIRE_OVF = 0;
    localparam int FIRE_UNF = 1;
    localparam int FIRE_SPP = 2;
    localparam int FIRE_W   = 3;

    // Bits needed to hold any occupancy from 0 to depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ovl_fifo_index_chan.sv
// One tracked FIFO channel: occupancy counter with clamping, violation pulses,
// sticky error, high-water mark and full/drain coverage pulses.
module ovl_fifo_index_chan
    import ovl_fifo_index_mc_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int PUSH_WIDTH     = 1,
    parameter int POP_WIDTH      = 1,
    parameter bit SIMUL_PUSH_POP = 1'b1,
    parameter int OCC_W          = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  clr_err_i,
    input  logic [PUSH_WIDTH-1:0] push_i,
    input  logic [POP_WIDTH-1:0]  pop_i,
    output logic [OCC_W-1:0]      occ_o,
    output logic [OCC_W-1:0]      high_water_o,
    output logic [FIRE_W-1:0]     fire_o,
    output logic                  err_sticky_o,
    output logic                  cov_full_o,
    output logic                  cov_drain_o
);

    // One extra bit beyond the widest operand keeps occ + push - pop from wrapping.
    localparam int NW = OCC_W + ((PUSH_WIDTH > POP_WIDTH) ? PUSH_WIDTH : POP_WIDTH) + 1;
    localparam logic signed [NW-1:0] DEPTH_S = NW'(DEPTH);
    localparam logic [OCC_W-1:0]     DEPTH_O = OCC_W'(DEPTH);

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  hw_q, hw_d;
    logic [FIRE_W-1:0] fire_q, fire_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic              drain_q, drain_d;
    logic signed [NW-1:0] next_s;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        occ_d   = occ_q;
        hw_d    = hw_q;
        fire_d  = '0;
        full_d  = 1'b0;
        drain_d = 1'b0;
        err_d   = clr_err_i ? 1'b0 : err_q;
        next_s  = $signed(NW'(occ_q)) + $signed(NW'(push_i)) - $signed(NW'(pop_i));

        if (enable_i) begin
            if (next_s > DEPTH_S) begin
                occ_d            = DEPTH_O;
                fire_d[FIRE_OVF] = 1'b1;
            end else if (next_s < 0) begin
                occ_d            = '0;
                fire_d[FIRE_UNF] = 1'b1;
            end else begin
                occ_d = OCC_W'(next_s);
            end

            if (!SIMUL_PUSH_POP && (push_i != '0) && (pop_i != '0))
                fire_d[FIRE_SPP] = 1'b1;

            if (occ_d > hw_q)
                hw_d = occ_d;

            full_d  = (occ_d == DEPTH_O) && (occ_q != DEPTH_O);
            drain_d = (occ_d == '0) && (occ_q != '0);

            // A fresh violation outranks a same-cycle clear.
            if (fire_d != '0)
                err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q   <= '0;
            hw_q    <= '0;
            fire_q  <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            hw_q    <= hw_d;
            fire_q  <= fire_d;
            err_q   <= err_d;
            full_q  <= full_d;
            drain_q <= drain_d;
        end
    end

    assign occ_o        = occ_q;
    assign high_water_o = hw_q;
    assign fire_o       = fire_q;
    assign err_sticky_o = err_q;
    assign cov_full_o   = full_q;
    assign cov_drain_o  = drain_q;

endmodule

// File: rtl/ovl_fifo_index_mc.sv
// Multi-channel FIFO index checker: slices the packed per-channel buses and
// instantiates one independent tracker per channel.
module ovl_fifo_index_mc
    import ovl_fifo_index_mc_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DEPTH          = 4,
    parameter int PUSH_WIDTH     = 1,
    parameter int POP_WIDTH      = 1,
    parameter bit SIMUL_PUSH_POP = 1'b1,
    parameter int OCC_W          = occ_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_CH*PUSH_WIDTH-1:0] push,
    input  logic [NUM_CH*POP_WIDTH-1:0]  pop,
    input  logic                         clr_err,
    output logic [NUM_CH*OCC_W-1:0]      occupancy,
    output logic [NUM_CH*OCC_W-1:0]      high_water,
    output logic [NUM_CH*FIRE_W-1:0]     fire,
    output logic [NUM_CH-1:0]            err_sticky,
    output logic [NUM_CH-1:0]            cov_full,
    output logic [NUM_CH-1:0]            cov_drain
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ovl_fifo_index_chan #(
            .DEPTH         (DEPTH),
            .PUSH_WIDTH    (PUSH_WIDTH),
            .POP_WIDTH     (POP_WIDTH),
            .SIMUL_PUSH_POP(SIMUL_PUSH_POP),
            .OCC_W         (OCC_W)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .enable_i    (enable),
            .clr_err_i   (clr_err),
            .push_i      (push[c*PUSH_WIDTH +: PUSH_WIDTH]),
            .pop_i       (pop[c*POP_WIDTH +: POP_WIDTH]),
            .occ_o       (occupancy[c*OCC_W +: OCC_W]),
            .high_water_o(high_water[c*OCC_W +: OCC_W]),
            .fire_o      (fire[c*FIRE_W +: FIRE_W]),
            .err_sticky_o(err_sticky[c]),
            .cov_full_o  (cov_full[c]),
            .cov_drain_o (cov_drain[c])
        );
    end

endmodule

// File: tb/tb_ovl_fifo_index_mc.sv
// Directed bench for ovl_fifo_index_mc with NUM_CH=2, DEPTH=4, 2-bit push,
// 1-bit pop and simultaneous push/pop flagged as illegal.
module tb_ovl_fifo_index_mc;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int PW     = 2;
    localparam int PPW    = 1;
    localparam int OW     = 3;

    logic                  clk;
    logic                  reset_n;
    logic                  enable;
    logic [NUM_CH*PW-1:0]  push;
    logic [NUM_CH*PPW-1:0] pop;
    logic                  clr_err;
    logic [NUM_CH*OW-1:0]  occupancy;
    logic [NUM_CH*OW-1:0]  high_water;
    logic [NUM_CH*3-1:0]   fire;
    logic [NUM_CH-1:0]     err_sticky;
    logic [NUM_CH-1:0]     cov_full;
    logic [NUM_CH-1:0]     cov_drain;

    int errors = 0;
    int checks = 0;

    ovl_fifo_index_mc #(
        .NUM_CH        (NUM_CH),
        .DEPTH         (DEPTH),
        .PUSH_WIDTH    (PW),
        .POP_WIDTH     (PPW),
        .SIMUL_PUSH_POP(1'b0)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .occupancy (occupancy),
        .high_water(high_water),
        .fire      (fire),
        .err_sticky(err_sticky),
        .cov_full  (cov_full),
        .cov_drain (cov_drain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {occ, hw, fire, err, full, drain} = 24 bits.
    function automatic logic [23:0] snap();
        return {occupancy, high_water, fire, err_sticky, cov_full, cov_drain};
    endfunction

    function automatic logic [23:0] mk(input logic [2:0] occ1, input logic [2:0] occ0,
                                       input logic [2:0] hw1, input logic [2:0] hw0,
                                       input logic [5:0] f, input logic [1:0] e,
                                       input logic [1:0] full, input logic [1:0] drain);
        return {occ1, occ0, hw1, hw0, f, e, full, drain};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] exp_v;
        reset_n = 1'b1; enable = 1'b1; push = '0; pop = '0; clr_err = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        exp_v = mk(0, 0, 0, 0, 6'b0, 2'b0, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", snap(), exp_v);
        end
        #10 reset_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [23:0] exp_v;
        push = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = mk(0, 3'(i + 1), 0, 3'(i + 1), 6'b0, 2'b0, (i == 3) ? 2'b01 : 2'b00, 2'b0);
            checks++;
            if (snap() !== exp_v) begin
                errors++;
                $display("FAIL fill_%0d: got %h want %h", i, snap(), exp_v);
            end
        end
        push = '0;
        step();
        exp_v = mk(0, 4, 0, 4, 6'b0, 2'b0, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL fill_hold: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] exp_v;
        push = 4'b0001;
        step();
        exp_v = mk(0, 4, 0, 4, 6'b000001, 2'b01, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL overflow_fire: got %h want %h", snap(), exp_v);
        end
        push = '0;
        step();
        exp_v = mk(0, 4, 0, 4, 6'b0, 2'b01, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL overflow_sticky: got %h want %h", snap(), exp_v);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        exp_v = mk(0, 4, 0, 4, 6'b0, 2'b00, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL overflow_clear: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_underflow_spp();
        logic [23:0] exp_v;
        pop = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = mk(0, 3'(3 - i), 0, 4, 6'b0, 2'b0, 2'b0, (i == 3) ? 2'b01 : 2'b00);
            checks++;
            if (snap() !== exp_v) begin
                errors++;
                $display("FAIL drain_%0d: got %h want %h", i, snap(), exp_v);
            end
        end
        step();
        exp_v = mk(0, 0, 0, 4, 6'b000010, 2'b01, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL underflow_fire: got %h want %h", snap(), exp_v);
        end
        push = 4'b0001; pop = 2'b01; clr_err = 1'b1;
        step();
        exp_v = mk(0, 0, 0, 4, 6'b000100, 2'b01, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL spp_fire_beats_clr: got %h want %h", snap(), exp_v);
        end
        push = '0; pop = '0;
        step();
        clr_err = 1'b0;
        exp_v = mk(0, 0, 0, 4, 6'b0, 2'b00, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL spp_clear: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_wide_push();
        logic [23:0] exp_v;
        push = 4'b1100;
        step();
        exp_v = mk(3, 0, 3, 4, 6'b0, 2'b0, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL wide_push3: got %h want %h", snap(), exp_v);
        end
        push = 4'b1100; pop = 2'b10;
        step();
        exp_v = mk(4, 0, 4, 4, 6'b101000, 2'b10, 2'b10, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL wide_overflow: got %h want %h", snap(), exp_v);
        end
        push = '0; pop = 2'b10;
        step();
        pop = '0;
        exp_v = mk(3, 0, 4, 4, 6'b0, 2'b10, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL wide_pop: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_enable();
        logic [23:0] exp_v;
        enable = 1'b0;
        push = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            clr_err = (i == 1);
            step();
            exp_v = mk(3, 0, 4, 4, 6'b0, (i >= 1) ? 2'b00 : 2'b10, 2'b0, 2'b0);
            checks++;
            if (snap() !== exp_v) begin
                errors++;
                $display("FAIL enable_off_%0d: got %h want %h", i, snap(), exp_v);
            end
        end
        enable = 1'b1; push = '0; clr_err = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [23:0] exp_v;
        push = 4'b0001;
        step();
        push = 4'b1101;
        step();
        push = '0;
        exp_v = mk(4, 2, 4, 4, 6'b001000, 2'b10, 2'b10, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL pre_reset: got %h want %h", snap(), exp_v);
        end
        #3 reset_n = 1'b0;
        #1;
        exp_v = mk(0, 0, 0, 0, 6'b0, 2'b0, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", snap(), exp_v);
        end
        #2 reset_n = 1'b1;
        push = 4'b0001;
        step();
        push = '0;
        exp_v = mk(0, 1, 0, 1, 6'b0, 2'b0, 2'b0, 2'b0);
        checks++;
        if (snap() !== exp_v) begin
            errors++;
            $display("FAIL post_reset: got %h want %h", snap(), exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow_spp();
        test_wide_push();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
